// File: rtl/controlador_contador.sv
// Command sequencer for the 7-stage shift/ring counter: turns one start strobe
// into the mode-select, serial-data and parallel-load drive that the counter needs.
module controlador_contador #(
  parameter int STEP_W = 4,
  parameter int NBITS  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [NBITS-1:0]  pattern,
  input  logic [STEP_W-1:0] steps,
  input  logic              stop,
  input  logic [NBITS-1:0]  saidas_contador,
  output logic              ch0,
  output logic              ch1,
  output logic              d,
  output logic [NBITS-1:0]  bits,
  output logic              busy,
  output logic              done,
  output logic [NBITS-1:0]  last_value
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_SHIFT  = 2'b01;
  localparam logic [1:0] CMD_ROTATE = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  state_t              state;
  logic [1:0]          cmd_reg;
  logic [NBITS-1:0]    pattern_reg;
  logic [STEP_W-1:0]   remaining;

  // Serial source consumed LSB first; zeros fill in once the pattern runs out.
  function automatic logic [NBITS-1:0] next_pattern(input logic [NBITS-1:0] p);
    return p >> 1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_reg     <= CMD_LOAD;
      pattern_reg <= '0;
      remaining   <= '0;
      {ch1, ch0}  <= MODE_HOLD;
      d           <= 1'b0;
      bits        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_value  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          {ch1, ch0} <= MODE_HOLD;
          d          <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            cmd_reg     <= cmd;
            pattern_reg <= pattern;
            remaining   <= steps;
            busy        <= 1'b1;
            if (cmd == CMD_LOAD || cmd == CMD_CLEAR) begin
              state      <= S_LOAD;
              {ch1, ch0} <= MODE_LOAD;
              bits       <= (cmd == CMD_LOAD) ? pattern : '0;
            end else if (steps == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (cmd == CMD_SHIFT) begin
              // First serial bit is presented on entry so the first RUN cycle is a real step.
              state       <= S_RUN;
              {ch1, ch0}  <= MODE_SHIFT;
              d           <= pattern[0];
              pattern_reg <= next_pattern(pattern);
            end else begin
              state      <= S_RUN;
              {ch1, ch0} <= MODE_ROTATE;
              d          <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          state      <= S_DONE;
          {ch1, ch0} <= MODE_HOLD;
          done       <= 1'b1;
        end

        S_RUN: begin
          remaining <= remaining - 1'b1;
          // A stop lets the step in flight finish; the mode drops to hold at this edge.
          if (remaining == STEP_W'(1) || stop) begin
            state      <= S_DONE;
            {ch1, ch0} <= MODE_HOLD;
            d          <= 1'b0;
            done       <= 1'b1;
          end else if (cmd_reg == CMD_SHIFT) begin
            d           <= pattern_reg[0];
            pattern_reg <= next_pattern(pattern_reg);
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          {ch1, ch0} <= MODE_HOLD;
          busy       <= 1'b0;
          last_value <= saidas_contador;
        end

        default: begin
          state      <= S_IDLE;
          {ch1, ch0} <= MODE_HOLD;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador with a behavioural model of the
// 7-stage counter closing the feedback loop.
module tb_controlador_contador;

  localparam logic [1:0] C_LOAD   = 2'b00;
  localparam logic [1:0] C_SHIFT  = 2'b01;
  localparam logic [1:0] C_ROTATE = 2'b10;
  localparam logic [1:0] C_CLEAR  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] cmd;
  logic [6:0] pattern;
  logic [3:0] steps;
  logic       stop;
  logic [6:0] saidas_contador;
  logic       ch0, ch1, d, busy, done;
  logic [6:0] bits, last_value;

  logic [6:0] cnt = 7'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  controlador_contador #(.STEP_W(4), .NBITS(7)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .pattern(pattern),
    .steps(steps), .stop(stop), .saidas_contador(saidas_contador),
    .ch0(ch0), .ch1(ch1), .d(d), .bits(bits), .busy(busy), .done(done),
    .last_value(last_value)
  );

  // Counter: 01 shift toward stage6 with d into stage0, 10 load, 11 rotate.
  always @(posedge clk) begin
    case ({ch1, ch0})
      2'b01:   cnt <= {cnt[5:0], d};
      2'b10:   cnt <= bits;
      2'b11:   cnt <= {cnt[5:0], cnt[6]};
      default: cnt <= cnt;
    endcase
  end
  assign saidas_contador = cnt;

  task automatic run_cmd(input logic [1:0] c, input logic [6:0] p, input logic [3:0] s,
                         input int stop_at, input int restart_at,
                         output int n_load, output int n_sh, output int n_rot,
                         output int done_edge, output logic [6:0] load_bits,
                         output logic [15:0] dseq);
    n_load = 0; n_sh = 0; n_rot = 0; done_edge = 0; load_bits = 7'h00; dseq = 16'h0000;
    @(negedge clk);
    cmd = c; pattern = p; steps = s; start = 1'b1;
    for (int e = 1; e <= 40 && done_edge == 0; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      case ({ch1, ch0})
        2'b10: begin n_load++; load_bits = bits; end
        2'b01: begin if (n_sh < 16) dseq[n_sh] = d; n_sh++; end
        2'b11: n_rot++;
        default: ;
      endcase
      if (done) done_edge = e;
      if (e == stop_at) stop = 1'b1;
      if (e == restart_at) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; cmd = 2'b00; pattern = 7'h00; steps = 4'h0; stop = 1'b0;
    #12;
    n_tests++;
    if ({ch1, ch0, d, busy, done} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ch1,ch0,d,busy,done=%b expected 00000", {ch1, ch0, d, busy, done});
    end
    n_tests++;
    if ({bits, last_value} !== 14'h0000) begin
      n_fail++;
      $display("FAIL reset_data: bits=%b last_value=%b expected 0", bits, last_value);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_LOAD, 7'h7f, 4'd0, 0, 0, nl, ns, nr, de, lb, ds);
    @(negedge clk);
    cmd = C_ROTATE; steps = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_tests++;
    if ({ch1, ch0, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL midrun_active: ch1,ch0,busy=%b expected 111", {ch1, ch0, busy});
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({ch1, ch0, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrun_async_reset: ch1,ch0,busy,done=%b expected 0000", {ch1, ch0, busy, done});
    end
    n_tests++;
    if ({bits, last_value} !== 14'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset_data: bits=%b last_value=%b expected 0", bits, last_value);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({ch1, ch0, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrun_no_resume: ch1,ch0,busy=%b expected 000", {ch1, ch0, busy});
    end
  endtask

  task automatic test_load;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_LOAD, 7'b1010011, 4'd0, 0, 0, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (nl !== 1 || lb !== 7'b1010011) begin
      n_fail++;
      $display("FAIL load_cycle: load cycles=%0d bits=%b expected 1 cycle bits=1010011", nl, lb);
    end
    n_tests++;
    if (de !== 2) begin
      n_fail++;
      $display("FAIL load_latency: done at %0d expected 2", de);
    end
    n_tests++;
    if ({last_value, busy, done} !== {7'b1010011, 2'b00}) begin
      n_fail++;
      $display("FAIL load_result: last_value=%b busy=%b done=%b expected 1010011 0 0", last_value, busy, done);
    end
  endtask

  task automatic test_rotate;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_ROTATE, 7'h00, 4'd3, 0, 0, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (nr !== 3 || ns !== 0 || nl !== 0) begin
      n_fail++;
      $display("FAIL rotate_cycles: rot=%0d shift=%0d load=%0d expected 3 0 0", nr, ns, nl);
    end
    n_tests++;
    if (de !== 4) begin
      n_fail++;
      $display("FAIL rotate_latency: done at %0d expected 4", de);
    end
    n_tests++;
    if (last_value !== 7'b0011101 || cnt !== 7'b0011101) begin
      n_fail++;
      $display("FAIL rotate_result: last_value=%b counter=%b expected 0011101", last_value, cnt);
    end
  endtask

  task automatic test_clear_shift;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_CLEAR, 7'h7f, 4'd5, 0, 0, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (nl !== 1 || lb !== 7'h00 || de !== 2 || last_value !== 7'h00) begin
      n_fail++;
      $display("FAIL clear: load=%0d bits=%b done_at=%0d last_value=%b expected 1 0000000 2 0000000", nl, lb, de, last_value);
    end
    run_cmd(C_SHIFT, 7'b0000101, 4'd7, 0, 0, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (ns !== 7 || ds[6:0] !== 7'b0000101) begin
      n_fail++;
      $display("FAIL shift_dseq: shifts=%0d d(first..last at bit0..6)=%b expected 7 0000101", ns, ds[6:0]);
    end
    n_tests++;
    if (de !== 8) begin
      n_fail++;
      $display("FAIL shift_latency: done at %0d expected 8", de);
    end
    n_tests++;
    if (last_value !== 7'b1010000 || cnt !== 7'b1010000) begin
      n_fail++;
      $display("FAIL shift_result: last_value=%b counter=%b expected 1010000", last_value, cnt);
    end
  endtask

  task automatic test_stop_and_busy_start;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_SHIFT, 7'b1111111, 4'd12, 5, 2, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (ns !== 5 || ds[4:0] !== 5'b11111) begin
      n_fail++;
      $display("FAIL stop_shifts: shifts=%0d d=%b expected 5 11111", ns, ds[4:0]);
    end
    n_tests++;
    if (de !== 6) begin
      n_fail++;
      $display("FAIL stop_latency: done at %0d expected 6", de);
    end
    n_tests++;
    if (last_value !== 7'b0011111) begin
      n_fail++;
      $display("FAIL stop_result: last_value=%b expected 0011111", last_value);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ch1, ch0, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL busy_start_ignored: ch1,ch0,busy,done=%b expected 0000", {ch1, ch0, busy, done});
    end
  endtask

  task automatic test_rotate_zero;
    int nl, ns, nr, de;
    logic [6:0] lb;
    logic [15:0] ds;
    run_cmd(C_ROTATE, 7'h00, 4'd0, 0, 0, nl, ns, nr, de, lb, ds);
    n_tests++;
    if (nl + ns + nr !== 0) begin
      n_fail++;
      $display("FAIL zero_active: active cycles=%0d expected 0", nl + ns + nr);
    end
    n_tests++;
    if (de !== 1) begin
      n_fail++;
      $display("FAIL zero_latency: done at %0d expected 1", de);
    end
    n_tests++;
    if ({last_value, done} !== {7'b0011111, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_result: last_value=%b done=%b expected 0011111 0", last_value, done);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_load();
    test_rotate();
    test_clear_shift();
    test_stop_and_busy_start();
    test_rotate_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
